if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit PMIPS datapath. Holds the program counter and drives the byte address into the combinational program memory. Captures the returned 16-bit instruction into the IF/ID pipeline register consumed by decode. Supports stall, flush and PC redirect (jump/branch) from later stages.

---
 rtl/if_fetch_stage.sv | 105 ++++++++++
 tb/tb_if_fetch_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage for the 16-bit PMIPS datapath: PC register and IF/ID pipeline register.
// Optional FETCH_COUNT_EN adds a saturating fetch_count output of accepted instructions.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] iaddr,
    input  logic [15:0] idata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc2,
    output logic        ifid_valid
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    localparam int unsigned XLEN = 16;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc2_q, pc2_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_plus2;
    logic            load_c;

    assign pc_plus2 = pc_q + XLEN'(2);

    // Priority: redirect > flush > stall > normal fetch.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        load_c  = 1'b0;
        if (redirect) begin
            pc_d    = {redirect_pc[XLEN-1:1], 1'b0};
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            if (!stall) begin
                pc_d = pc_plus2;
            end
        end else if (!stall) begin
            pc_d    = pc_plus2;
            instr_d = idata;
            pc2_d   = pc_plus2;
            valid_d = 1'b1;
            load_c  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

    assign iaddr      = pc_q;
    assign ifid_instr = instr_q;
    assign ifid_pc2   = pc2_q;
    assign ifid_valid = valid_q;

`ifdef FETCH_COUNT_EN
    logic [XLEN-1:0] count_q, count_d;

    // Counts accepted instructions, sticking at all-ones.
    always_comb begin
        count_d = count_q;
        if (load_c && (count_q != {XLEN{1'b1}})) begin
            count_d = count_q + XLEN'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`else
    logic unused_load;
    assign unused_load = load_c;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed vectors push expected IF/ID state, a monitor checks it.
// Define FETCH_COUNT_EN to also check fetch_count.
module tb_if_fetch_stage;

    logic        clock;
    logic        reset;
    logic [15:0] iaddr;
    logic [15:0] idata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc2;
    logic        ifid_valid;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    if_fetch_stage #(.RESET_PC(16'h0000), .NOP_WORD(16'h0000)) dut (
        .clock       (clock),
        .reset       (reset),
        .iaddr       (iaddr),
        .idata       (idata),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_instr  (ifid_instr),
        .ifid_pc2    (ifid_pc2),
        .ifid_valid  (ifid_valid)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program memory contents, zero-wait.
    function automatic logic [15:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: mem = 16'h6083;
            16'h0002: mem = 16'h6103;
            16'h0004: mem = 16'h6183;
            16'h0006: mem = 16'h6203;
            16'h0008: mem = 16'h6283;
            default:  mem = {4'h7, a[11:0]};
        endcase
    endfunction

    always_comb idata = mem(iaddr);

    typedef struct {
        logic        rst_n;
        logic        st;
        logic        fl;
        logic        rd;
        logic [15:0] rpc;
        logic [15:0] e_iaddr;
        logic [15:0] e_instr;
        logic [15:0] e_pc2;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] e_iaddr;
        logic [15:0] e_instr;
        logic [15:0] e_pc2;
        logic        e_valid;
        logic [15:0] e_cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   stim_done = 0;

    task automatic add(input logic r, input logic s, input logic f, input logic d,
                       input logic [15:0] rp, input logic [15:0] ia, input logic [15:0] ins,
                       input logic [15:0] p2, input logic v, input logic [15:0] c);
        vec_t t;
        t.rst_n = r; t.st = s; t.fl = f; t.rd = d; t.rpc = rp;
        t.e_iaddr = ia; t.e_instr = ins; t.e_pc2 = p2; t.e_valid = v; t.e_cnt = c;
        vecs.push_back(t);
    endtask

    // Monitor: one registered IF/ID result per edge, checked 1 time unit after it.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (iaddr !== e.e_iaddr) begin
                n_fail++;
                $display("FAIL v%0d iaddr: got %h want %h", e.idx, iaddr, e.e_iaddr);
            end
            if (ifid_instr !== e.e_instr) begin
                n_fail++;
                $display("FAIL v%0d ifid_instr: got %h want %h", e.idx, ifid_instr, e.e_instr);
            end
            if (ifid_pc2 !== e.e_pc2) begin
                n_fail++;
                $display("FAIL v%0d ifid_pc2: got %h want %h", e.idx, ifid_pc2, e.e_pc2);
            end
            if (ifid_valid !== e.e_valid) begin
                n_fail++;
                $display("FAIL v%0d ifid_valid: got %b want %b", e.idx, ifid_valid, e.e_valid);
            end
`ifdef FETCH_COUNT_EN
            if (fetch_count !== e.e_cnt) begin
                n_fail++;
                $display("FAIL v%0d fetch_count: got %h want %h", e.idx, fetch_count, e.e_cnt);
            end
`endif
        end
    end

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        //  rst st fl rd  rpc       iaddr     instr     pc2       v  cnt
        add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        add(1, 0, 0, 0, 16'h0000, 16'h0002, 16'h6083, 16'h0002, 1, 16'd1);
        add(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h6103, 16'h0004, 1, 16'd2);
        add(1, 1, 0, 0, 16'h0000, 16'h0004, 16'h6103, 16'h0004, 1, 16'd2);
        add(1, 1, 0, 0, 16'h0000, 16'h0004, 16'h6103, 16'h0004, 1, 16'd2);
        add(1, 1, 0, 0, 16'h0000, 16'h0004, 16'h6103, 16'h0004, 1, 16'd2);
        add(1, 0, 0, 0, 16'h0000, 16'h0006, 16'h6183, 16'h0006, 1, 16'd3);
        add(1, 0, 0, 0, 16'h0000, 16'h0008, 16'h6203, 16'h0008, 1, 16'd4);
        add(1, 0, 0, 0, 16'h0000, 16'h000A, 16'h6283, 16'h000A, 1, 16'd5);
        // redirect with odd target: bit 0 masked
        add(1, 0, 0, 1, 16'h0003, 16'h0002, 16'h0000, 16'h000A, 0, 16'd5);
        add(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h6103, 16'h0004, 1, 16'd6);
        // redirect beats stall and flush, then stall+flush holds pc
        add(1, 1, 1, 1, 16'h0020, 16'h0020, 16'h0000, 16'h0004, 0, 16'd6);
        add(1, 1, 1, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0004, 0, 16'd6);
        add(1, 0, 0, 0, 16'h0000, 16'h0022, 16'h7020, 16'h0022, 1, 16'd7);
        // flush alone advances pc and drops the word
        add(1, 0, 1, 0, 16'h0000, 16'h0024, 16'h0000, 16'h0022, 0, 16'd7);
        // wrap at top of address space
        add(1, 0, 0, 1, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0022, 0, 16'd7);
        add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h7FFE, 16'h0000, 1, 16'd8);
        // reset during stall clears everything
        add(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        add(1, 0, 0, 0, 16'h0000, 16'h0002, 16'h6083, 16'h0002, 1, 16'd1);
        add(1, 0, 0, 0, 16'h0000, 16'h0004, 16'h6103, 16'h0004, 1, 16'd2);
        add(1, 0, 0, 0, 16'h0000, 16'h0006, 16'h6183, 16'h0006, 1, 16'd3);
        add(1, 0, 0, 0, 16'h0000, 16'h0008, 16'h6203, 16'h0008, 1, 16'd4);
        add(1, 0, 0, 0, 16'h0000, 16'h000A, 16'h6283, 16'h000A, 1, 16'd5);
        add(1, 1, 0, 0, 16'h0000, 16'h000A, 16'h6283, 16'h000A, 1, 16'd5);
        add(1, 1, 0, 0, 16'h0000, 16'h000A, 16'h6283, 16'h000A, 1, 16'd5);
        add(1, 0, 1, 0, 16'h0000, 16'h000C, 16'h0000, 16'h000A, 0, 16'd5);
        add(1, 0, 0, 0, 16'h0000, 16'h000E, 16'h700C, 16'h000E, 1, 16'd6);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clock);
            reset       = vecs[i].rst_n;
            stall       = vecs[i].st;
            flush       = vecs[i].fl;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            e.idx     = i;
            e.e_iaddr = vecs[i].e_iaddr;
            e.e_instr = vecs[i].e_instr;
            e.e_pc2   = vecs[i].e_pc2;
            e.e_valid = vecs[i].e_valid;
            e.e_cnt   = vecs[i].e_cnt;
            sb.push_back(e);
            n_vec++;
        end

        @(negedge clock);
        stall = 1'b1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clock);
        end
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected results never checked, want 0", sb.size());
        end
        stim_done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog: run not finished at %0t, want done", $time);
            $fatal(1, "watchdog expired");
        end
    end

endmodule
